// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave core.
package spi_pkg;

  // Frame-level state of the slave.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_e;

  localparam int unsigned SPI_DATA_W_DEF = 8;
  localparam int unsigned SPI_DATA_W_MAX = 32;

  // Word shifted out when the master clocks a word and no tx data is waiting.
  localparam logic [SPI_DATA_W_MAX-1:0] SPI_UNDERRUN_FILL = '0;

endpackage

// File: rtl/spi_sync.sv
// Multi-stage synchronizer for one asynchronous input, with rise/fall detect
// on the synchronized value.
module spi_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_b,
  input  logic d_in,
  output logic sync_o,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] chain_q, chain_d;
  logic              prev_q, prev_d;

  // Next value of the synchronizer chain and the edge-detect history flop.
  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d_in};
    prev_d  = chain_q[STAGES-1];
  end

  // Chain and history registers; reset to the line's idle level.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      chain_q <= {STAGES{RST_VAL}};
      prev_q  <= RST_VAL;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  assign sync_o = chain_q[STAGES-1];
  assign rise_c = sync_o & ~prev_q;
  assign fall_c = ~sync_o & prev_q;

endmodule

// File: rtl/spi_slave_core.sv
// SPI mode-0 slave (MSB first) with one-entry tx buffer and valid/ready rx port.
// Optional build macro SPI_SLAVE_CORE_ECHO_EN: on tx underrun, shift out the
// last word committed to rx_data instead of the all-zero fill.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = SPI_DATA_W_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              sclk,
  input  logic              cs_b,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_overrun,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int unsigned       CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
  localparam int unsigned       FLUSH_W  = SYNC_STAGES + 1;

  // Synchronized inputs and edge strobes
  logic sclk_sync, sclk_rise_c, sclk_fall_c;
  logic cs_sync, cs_rise_c, cs_fall_c;
  logic [SYNC_STAGES-1:0] mosi_chain_q, mosi_chain_d;
  logic mosi_sync;

  // Frame state and datapath registers
  spi_state_e        state_q, state_d;
  logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
  logic              tx_empty_q, tx_empty_d;
  logic [DATA_W-2:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-2:0] rx_shift_q, rx_shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              load_pend_q, load_pend_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_overrun_q, rx_overrun_d;
  logic              tx_underrun_q, tx_underrun_d;
  logic              miso_q, miso_d;
  logic              busy_q, busy_d;
  logic              armed_q, armed_d;
  logic [FLUSH_W-1:0] flush_q, flush_d;

  logic              load_c, word_done_c, commit_c;
  logic [DATA_W-1:0] rx_word_c, load_val_c, fill_c;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk    (clk),
    .rst_b  (rst_b),
    .d_in   (sclk),
    .sync_o (sclk_sync),
    .rise_c (sclk_rise_c),
    .fall_c (sclk_fall_c)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk    (clk),
    .rst_b  (rst_b),
    .d_in   (cs_b),
    .sync_o (cs_sync),
    .rise_c (cs_rise_c),
    .fall_c (cs_fall_c)
  );

  assign mosi_sync = mosi_chain_q[SYNC_STAGES-1];
  assign rx_word_c = {rx_shift_q, mosi_sync};

`ifdef SPI_SLAVE_CORE_ECHO_EN
  logic [DATA_W-1:0] echo_q, echo_d;

  // Remember the last word handed to the rx port for underrun echo.
  always_comb begin
    echo_d = echo_q;
    if (commit_c) echo_d = rx_word_c;
  end

  // Echo register, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_b) echo_q <= '0;
    else        echo_q <= echo_d;
  end

  assign fill_c = echo_q;
`else
  assign fill_c = DATA_W'(SPI_UNDERRUN_FILL);
`endif

  // Next-state, datapath and output computation.
  always_comb begin
    state_d       = state_q;
    tx_buf_d      = tx_buf_q;
    tx_empty_d    = tx_empty_q;
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    bit_cnt_d     = bit_cnt_q;
    load_pend_d   = load_pend_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    rx_overrun_d  = 1'b0;
    tx_underrun_d = 1'b0;
    miso_d        = miso_q;
    busy_d        = busy_q;
    armed_d       = armed_q;
    flush_d       = {flush_q[FLUSH_W-2:0], 1'b1};
    mosi_chain_d  = {mosi_chain_q[SYNC_STAGES-2:0], mosi};
    load_c        = 1'b0;
    word_done_c   = 1'b0;
    commit_c      = 1'b0;
    load_val_c    = '0;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        miso_d      = 1'b0;
        busy_d      = 1'b0;
        bit_cnt_d   = '0;
        rx_shift_d  = '0;
        load_pend_d = 1'b0;
        // Only a cs_b fall seen after the chain has refilled with real
        // samples may open a frame; this blocks re-entry after a reset
        // that arrived while cs_b was already low.
        if (flush_q[FLUSH_W-1] && cs_sync) armed_d = 1'b1;
        if (cs_fall_c && armed_q) begin
          state_d = ST_SHIFT;
          busy_d  = 1'b1;
          armed_d = 1'b0;
          load_c  = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (cs_rise_c) begin
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          miso_d      = 1'b0;
          bit_cnt_d   = '0;
          rx_shift_d  = '0;
          load_pend_d = 1'b0;
        end else if (sclk_rise_c && sclk_sync) begin
          rx_shift_d = rx_word_c[DATA_W-2:0];
          if (bit_cnt_q == CNT_LAST) begin
            bit_cnt_d   = '0;
            load_pend_d = 1'b1;
            word_done_c = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (sclk_fall_c) begin
          if (load_pend_q) begin
            load_pend_d = 1'b0;
            load_c      = 1'b1;
          end else begin
            miso_d     = tx_shift_q[DATA_W-2];
            tx_shift_d = {tx_shift_q[DATA_W-3:0], 1'b0};
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Word completion: a pending, unconsumed word blocks the new one.
    if (word_done_c) begin
      if (rx_valid_q && !rx_ready) begin
        rx_overrun_d = 1'b1;
      end else begin
        rx_data_d  = rx_word_c;
        rx_valid_d = 1'b1;
        commit_c   = 1'b1;
      end
    end

    // Load point: move buffered word (or fill) into the tx shifter.
    if (load_c) begin
      if (tx_empty_q) begin
        load_val_c    = fill_c;
        tx_underrun_d = 1'b1;
      end else begin
        load_val_c = tx_buf_q;
        tx_empty_d = 1'b1;
      end
      miso_d     = load_val_c[DATA_W-1];
      tx_shift_d = load_val_c[DATA_W-2:0];
    end

    if (tx_valid && tx_empty_q) begin
      tx_buf_d   = tx_data;
      tx_empty_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q       <= ST_IDLE;
      tx_buf_q      <= '0;
      tx_empty_q    <= 1'b1;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      bit_cnt_q     <= '0;
      load_pend_q   <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
      miso_q        <= 1'b0;
      busy_q        <= 1'b0;
      armed_q       <= 1'b0;
      flush_q       <= '0;
      mosi_chain_q  <= '0;
    end else begin
      state_q       <= state_d;
      tx_buf_q      <= tx_buf_d;
      tx_empty_q    <= tx_empty_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      bit_cnt_q     <= bit_cnt_d;
      load_pend_q   <= load_pend_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
      miso_q        <= miso_d;
      busy_q        <= busy_d;
      armed_q       <= armed_d;
      flush_q       <= flush_d;
      mosi_chain_q  <= mosi_chain_d;
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = busy_q;
  assign busy        = busy_q;
  assign tx_ready    = tx_empty_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = rx_overrun_q;
  assign tx_underrun = tx_underrun_q;

endmodule

// File: doc/spi_slave_core.md
SPI_SLAVE_CORE -- requirements
Module: spi_slave_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8, word length in bits (legal 4..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on sclk/cs_b/mosi (legal 2..3).
REQ-003 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst_b  in  1  synchronous, active-low reset.
REQ-005 SHALL have port sclk  in  1  SPI clock from master, asynchronous to clk.
REQ-006 SHALL have port cs_b  in  1  active-low chip select from master, asynchronous.
REQ-007 SHALL have port mosi  in  1  serial data from master, asynchronous.
REQ-008 SHALL have port miso  out  1  serial data to master.
REQ-009 SHALL have port miso_oe  out  1  miso output enable, high while frame active.
REQ-010 SHALL have ports tx_data in DATA_W, tx_valid in 1, tx_ready out 1: word to send, valid/ready handshake.
REQ-011 SHALL have ports rx_data out DATA_W, rx_valid out 1, rx_ready in 1: received word, valid/ready handshake.
REQ-012 SHALL have ports rx_overrun out 1 and tx_underrun out 1: single-cycle error pulses.
REQ-013 SHALL have port busy  out  1  high while synchronized cs_b is low.

Function
REQ-014 SHALL implement SPI mode 0 (CPOL=0, CPHA=0), MSB first: sample mosi on sclk rise, update miso on sclk fall.
REQ-015 SHALL detect sclk/cs_b edges only on synchronized signals; clk frequency SHALL be >= 8x sclk frequency.
REQ-016 SHALL have FSM IDLE and SHIFT: IDLE->SHIFT on synced cs_b fall; SHIFT->IDLE on synced cs_b rise; no other transitions.
REQ-017 SHALL hold one-entry tx buffer; tx_ready = buffer empty; word captured in cycle where tx_valid && tx_ready.
REQ-018 On IDLE->SHIFT, and on the sclk fall following each completed word, SHALL load tx buffer into tx shift register and empty buffer; miso = its MSB in the next clk cycle.
REQ-019 If buffer empty at a load point, SHALL load all-zeros and pulse tx_underrun for one cycle.
REQ-020 On each synced sclk rise in SHIFT, SHALL shift synced mosi into rx shift register LSB and increment a bit counter (wraps at DATA_W).
REQ-021 On the DATA_W-th sclk rise, SHALL, in the next clk cycle, copy the word to rx_data and set rx_valid, unless rx_valid is already high.
REQ-022 If rx_valid is high at word completion, SHALL keep old rx_data, discard new word, pulse rx_overrun.
REQ-023 SHALL clear rx_valid in cycle after rx_valid && rx_ready; new-word set in same cycle as clear SHALL win (rx_valid stays 1, rx_data updated).
REQ-024 On cs_b rise mid-word, SHALL discard partial rx bits, reset bit counter, leave tx buffer unchanged, drive miso 0.
REQ-025 SHALL drive miso_oe = busy; miso = 0 when miso_oe low.

Reset
REQ-026 While rst_b low at clk rise SHALL set: FSM IDLE, miso 0, miso_oe 0, busy 0, tx_ready 1, tx buffer empty, rx_valid 0, rx_data 0, rx_overrun 0, tx_underrun 0, counter 0, synchronizer flops to idle (sclk 0, cs_b 1, mosi 0).
REQ-027 Reset asserted mid-frame SHALL abort; after release the block SHALL wait for a fresh cs_b fall before shifting.

Configuration
REQ-028 With macro SPI_SLAVE_CORE_ECHO_EN defined, underrun load SHALL use last successfully received rx word (zero after reset) instead of all-zeros; tx_underrun still pulses. Without it, REQ-019 applies unchanged.

Structure
REQ-029 Package spi_pkg SHALL hold the FSM state enum, default DATA_W constant and underrun fill constant.
REQ-030 Sub-module spi_sync SHALL implement the SYNC_STAGES synchronizer plus rise/fall detect, instantiated for sclk and cs_b; mosi synchronized only.

Verification
REQ-031 tx 0xA5 preloaded, master sends 0x3C in one frame -> miso bits 1,0,1,0,0,1,0,1; rx_data 0x3C, rx_valid 1.
REQ-032 Three back-to-back words 0x01,0x02,0x03 under one cs_b, rx_ready always 1 -> three rx_valid handshakes in order, no errors.
REQ-033 rx_ready held 0, two words 0x11,0x22 -> rx_data 0x11, one rx_overrun pulse.
REQ-034 No tx word loaded, frame 0x55 -> tx_underrun pulse, miso all 0 (ECHO_EN: second frame returns 0x55).
REQ-035 cs_b raised after 3 bits of 0xFF, then full frame 0x81 -> only 0x81 received, busy tracks cs_b.
REQ-036 rst_b low mid-frame for 2 cycles -> all outputs at reset values; next complete frame 0x7E received correctly.
